axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
- Sequencer that turns simple single-beat register commands (write or read) into AXI4-Lite master transactions. Drives the AXI-Lite slave register blocks (e.g. `demo`).
- Sits between a firmware/init command source (FIFO or ROM walker) and one AXI-Lite slave port.
- Runs one transaction at a time; every command returns exactly one response.

Parameters:
- ADDR_WIDTH, 32: AXI and command address width.
- TIMEOUT_CYCLES, 256: response-wait limit, used only with AXI_CMD_TIMEOUT_EN; minimum 2.

Ports:
- i_axi_clk in 1: single clock.
- i_axi_rst_n in 1: reset, asynchronous assert, active-low (already decided).
- i_cmd_valid in 1: command present.
- o_cmd_ready out 1: command accepted this cycle.
- i_cmd_write in 1: 1 = write, 0 = read.
- i_cmd_addr in ADDR_WIDTH: byte address.
- i_cmd_wdata in 32: write data.
- i_cmd_wstrb in 4: write strobes.
- o_rsp_valid out 1: response present.
- i_rsp_ready in 1: response consumed.
- o_rsp_rdata out 32: read data; 0 for writes.
- o_rsp_resp out 2: AXI resp code.
- o_busy out 1: state != IDLE.
- o_awvalid out 1, o_awaddr out ADDR_WIDTH, i_awready in 1: write address channel.
- o_wvalid out 1, o_wdata out 32, o_wstrb out 4, i_wready in 1: write data channel.
- i_bvalid in 1, o_bready out 1, i_bresp in 2: write response channel.
- o_arvalid out 1, o_araddr out ADDR_WIDTH, i_arready in 1: read address channel.
- i_rvalid in 1, o_rready out 1, i_rresp in 2, i_rdata in 32: read data channel.

Behaviour:
- Reset: all valids/readys = 0, addr/data/strb/rdata/resp = 0, state = IDLE.
- Reset is asynchronous and aborts any in-flight transaction. No response is issued for it.
- o_cmd_ready = (state==IDLE), combinational. Command is captured into registers on i_cmd_valid & o_cmd_ready.
- IDLE: on accept, go to WR (write) or RD_ADDR (read). Channel valids rise the next cycle (1-cycle latency).
- WR:
  - o_awvalid and o_wvalid rise together.
  - Each drops independently after its own handshake, tracked by aw_done/w_done flags.
  - When both are done, go to WR_RESP. AW and W may complete in either order or in the same cycle.
- WR_RESP: o_bready = 1. On i_bvalid, latch i_bresp, set rdata = 0, go to RSP.
- RD_ADDR: o_arvalid = 1 until i_arready, then go to RD_DATA.
- RD_DATA: o_rready = 1. On i_rvalid, latch i_rdata and i_rresp, go to RSP.
- RSP:
  - o_rsp_valid = 1; data and resp are held stable until i_rsp_ready.
  - On i_rsp_ready go to IDLE. The next command can be accepted the cycle after.
- Once asserted, AW/W/AR valids and their payloads are never dropped or changed before the handshake (AXI rule).
- Slave resp codes (SLVERR/DECERR) are passed through unchanged; no retry.
- A B or R beat arriving early is ignored until its ready is asserted; the slave holds valid.
- Minimum write latency, accept to o_rsp_valid with a zero-wait slave: 3 cycles. Read: 3 cycles.

Optional Feature:
- Macro: AXI_CMD_TIMEOUT_EN.
- Enabled:
  - A counter runs in WR_RESP and RD_DATA and resets on state entry.
  - After TIMEOUT_CYCLES without a beat, go to RSP with o_rsp_resp = 2'b11 and rdata = 0.
  - A sticky drain flag is set. While set, o_cmd_ready stays low in IDLE, o_bready/o_rready = 1, and the next B/R beat is silently discarded, then the flag clears.
  - Address/data phases never time out.
- Disabled: no counter, no drain flag; the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds: state encoding (IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP), resp constants (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), data width 32, strobe width 4.
- No sub-module needed. The optional timeout counter is inline.

Test Plan:
- Write 0x0000_0004 ← 0xDEADBEEF, strb 0xF, zero-wait slave: AW/W valid on cycle 1; o_rsp_valid on cycle 3 with resp 0, rdata 0.
- Read 0x0000_0004 after the write: o_araddr = 4, o_rsp_rdata = 0xDEADBEEF, resp 0.
- Slave asserts wready 3 cycles before awready: both valids held correctly, exactly one B accepted, one response.
- i_rsp_ready low for 5 cycles: response held stable, o_cmd_ready stays 0, and a new command presented meanwhile is not accepted.
- Reset pulled low in RD_DATA: all outputs 0 immediately; after release, a write to 0x8 completes normally.
- With AXI_CMD_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave withholds bvalid: response resp = 3 after 16 cycles. A late bvalid is drained, then the next command is accepted.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: command-master state encoding, response codes and bus widths.
package axi_lite_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-beat command to AXI4-Lite master sequencer; one transaction in flight, one response per command.
// Optional response-wait timeout with drain of the late beat: define AXI_CMD_TIMEOUT_EN.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  i_axi_clk,
  input  logic                  i_axi_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  input  logic [STRB_WIDTH-1:0] i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_busy,
  output logic                  o_awvalid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  input  logic                  i_awready,
  output logic                  o_wvalid,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [STRB_WIDTH-1:0] o_wstrb,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [1:0]            i_rresp,
  input  logic [DATA_WIDTH-1:0] i_rdata
);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata, w_rdata_nxt;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [1:0]            r_resp, w_resp_nxt;
  logic                  r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;
  logic                  w_cmd_fire, w_aw_ok, w_w_ok, w_tmo_hit, w_drain;

`ifdef AXI_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_drain, w_set_drain;

  assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_set_drain = w_tmo_hit && (((r_state == ST_WR_RESP) && !i_bvalid) ||
                                     ((r_state == ST_RD_DATA) && !i_rvalid));
  assign w_drain     = r_drain;

  // Counter restarts on every state change so each response wait starts from zero.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      r_tmo_cnt <= '0;
      r_drain   <= 1'b0;
    end else begin
      if (r_state != w_state_nxt)
        r_tmo_cnt <= '0;
      else if ((r_state == ST_WR_RESP) || (r_state == ST_RD_DATA))
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_set_drain)
        r_drain <= 1'b1;
      else if (r_drain && (i_bvalid || i_rvalid))
        r_drain <= 1'b0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign w_drain   = 1'b0;
`endif

  // Ready is gated by reset so every ready/valid reads 0 while reset is held.
  assign o_cmd_ready = i_axi_rst_n && (r_state == ST_IDLE) && !w_drain;
  assign w_cmd_fire  = i_cmd_valid && o_cmd_ready;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_awvalid   = (r_state == ST_WR) && !r_aw_done;
  assign o_wvalid    = (r_state == ST_WR) && !r_w_done;
  assign o_bready    = (r_state == ST_WR_RESP) || w_drain;
  assign o_arvalid   = (r_state == ST_RD_ADDR);
  assign o_rready    = (r_state == ST_RD_DATA) || w_drain;
  assign o_rsp_valid = (r_state == ST_RSP);
  assign o_awaddr    = r_addr;
  assign o_araddr    = r_addr;
  assign o_wdata     = r_wdata;
  assign o_wstrb     = r_wstrb;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_resp  = r_resp;

  assign w_aw_ok = r_aw_done || i_awready;
  assign w_w_ok  = r_w_done  || i_wready;

  always_comb begin
    w_state_nxt    = r_state;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_rdata_nxt    = r_rdata;
    w_resp_nxt     = r_resp;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_state_nxt   = i_cmd_write ? ST_WR : ST_RD_ADDR;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      ST_WR: begin
        if (w_aw_ok && w_w_ok) begin
          w_state_nxt   = ST_WR_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = w_aw_ok;
          w_w_done_nxt  = w_w_ok;
        end
      end
      ST_WR_RESP: begin
        if (i_bvalid) begin
          w_resp_nxt  = i_bresp;
          w_rdata_nxt = '0;
          w_state_nxt = ST_RSP;
        end else if (w_tmo_hit) begin
          w_resp_nxt  = RESP_DECERR;
          w_rdata_nxt = '0;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (i_arready) w_state_nxt = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (i_rvalid) begin
          w_resp_nxt  = i_rresp;
          w_rdata_nxt = i_rdata;
          w_state_nxt = ST_RSP;
        end else if (w_tmo_hit) begin
          w_resp_nxt  = RESP_DECERR;
          w_rdata_nxt = '0;
          w_state_nxt = ST_RSP;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
    if (!i_axi_rst_n) begin
      r_state   <= ST_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_resp    <= w_resp_nxt;
      if (w_cmd_fire) begin
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
        r_wstrb <= i_cmd_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master: directed steps plus randomized commands against a word-level model.
module tb_axi_lite_cmd_master;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cmd_valid, i_cmd_write, i_rsp_ready;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_wdata;
  logic [3:0]    i_cmd_wstrb;
  logic          o_cmd_ready, o_rsp_valid, o_busy;
  logic [31:0]   o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic          o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [31:0]   o_wdata, i_rdata;
  logic [3:0]    o_wstrb;
  logic [1:0]    i_bresp, i_rresp;
  logic          o_arvalid, i_arready, i_rvalid, o_rready;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_axi_clk(clk), .i_axi_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_busy(o_busy),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
    .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  int unsigned checks = 0, failures = 0;
  int unsigned cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  int unsigned b_count = 0, r_count = 0;
  logic [31:0] last_awaddr = '0, last_araddr = '0;
  logic [7:0]  slv_bytes [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave address map: 0x.E.. answers SLVERR, 0x.D.. answers DECERR, everything else OKAY.
  function automatic logic [1:0] slv_resp(input logic [31:0] a);
    if (a[11:8] == 4'hE) return 2'd2;
    if (a[11:8] == 4'hD) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++)
      if (slv_bytes.exists(a + 32'(i))) v[8*i +: 8] = slv_bytes[a + 32'(i)];
    return v;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    logic [31:0] old  = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    ref_mem[a] = (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Behavioural AXI-Lite slave; decides readies/valids at negedge so each handshake lands on the next posedge.
  initial begin : slave
    logic aw_got, w_got, b_pend, b_fire, ar_got, r_pend, r_fire, pv_aw, pv_w, pv_ar;
    logic [31:0] aw_a, ar_a, w_d, pv_awaddr, pv_araddr, pv_wdata;
    logic [3:0]  w_s, pv_wstrb;
    logic [1:0]  rs;
    int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
    {aw_got, w_got, b_pend, b_fire, ar_got, r_pend, r_fire, pv_aw, pv_w, pv_ar} = '0;
    {aw_a, ar_a, w_d, pv_awaddr, pv_araddr, pv_wdata, w_s, pv_wstrb} = '0;
    {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
    {i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rresp, i_rdata} = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_got, w_got, b_pend, b_fire, ar_got, r_pend, r_fire, pv_aw, pv_w, pv_ar} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
        {i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rresp, i_rdata} = '0;
        continue;
      end
      if (pv_aw) check("aw_stable", {31'd0, o_awvalid, o_awaddr}, {31'd0, 1'b1, pv_awaddr});
      if (pv_w)  check("w_stable", {27'd0, o_wvalid, o_wstrb, o_wdata}, {27'd0, 1'b1, pv_wstrb, pv_wdata});
      if (pv_ar) check("ar_stable", {31'd0, o_arvalid, o_araddr}, {31'd0, 1'b1, pv_araddr});
      if (b_fire) begin i_bvalid = 1'b0; b_fire = 1'b0; b_pend = 1'b0; b_count++; end
      if (!b_pend && aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_wait = 0;
        rs = slv_resp(aw_a); i_bresp = rs;
        if (rs == 2'd0)
          for (int i = 0; i < 4; i++) if (w_s[i]) slv_bytes[aw_a + 32'(i)] = w_d[8*i +: 8];
      end
      if (b_pend) begin
        if (b_wait < cfg_b_dly) b_wait++;
        else begin i_bvalid = 1'b1; b_fire = o_bready; end
      end
      i_awready = 1'b0; pv_aw = 1'b0;
      if (o_awvalid) begin
        if (aw_wait < cfg_aw_dly) begin aw_wait++; pv_aw = 1'b1; pv_awaddr = o_awaddr; end
        else begin i_awready = 1'b1; aw_got = 1'b1; aw_a = o_awaddr; aw_wait = 0; last_awaddr = o_awaddr; end
      end
      i_wready = 1'b0; pv_w = 1'b0;
      if (o_wvalid) begin
        if (w_wait < cfg_w_dly) begin w_wait++; pv_w = 1'b1; pv_wdata = o_wdata; pv_wstrb = o_wstrb; end
        else begin i_wready = 1'b1; w_got = 1'b1; w_d = o_wdata; w_s = o_wstrb; w_wait = 0; end
      end
      if (r_fire) begin i_rvalid = 1'b0; r_fire = 1'b0; r_pend = 1'b0; r_count++; end
      if (!r_pend && ar_got) begin
        ar_got = 1'b0; r_pend = 1'b1; r_wait = 0;
        rs = slv_resp(ar_a); i_rresp = rs;
        i_rdata = (rs == 2'd0) ? slv_read(ar_a) : (32'hBAD0_0000 | ar_a);
      end
      if (r_pend) begin
        if (r_wait < cfg_r_dly) r_wait++;
        else begin i_rvalid = 1'b1; r_fire = o_rready; end
      end
      i_arready = 1'b0; pv_ar = 1'b0;
      if (o_arvalid) begin
        if (ar_wait < cfg_ar_dly) begin ar_wait++; pv_ar = 1'b1; pv_araddr = o_araddr; end
        else begin i_arready = 1'b1; ar_got = 1'b1; ar_a = o_araddr; ar_wait = 0; last_araddr = o_araddr; end
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting posedge (cycle 1).
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n = 0;
    i_cmd_write = wr; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s; i_cmd_valid = 1'b1;
    while (!o_cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!o_cmd_ready) check("cmd_accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic wr, output logic [31:0] rd, output logic [1:0] rs,
                          output int unsigned lat, output logic v1);
    lat = 1;
    v1  = wr ? (o_awvalid & o_wvalid) : o_arvalid;
    while (!o_rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    if (!o_rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    rd = o_rsp_rdata; rs = o_rsp_resp;
    if (i_rsp_ready) @(negedge clk);
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input string tag);
    logic [31:0] rd, exp_rd;
    logic [1:0]  rs, exp_rs;
    int unsigned lat, exp_lat;
    logic        v1;
    exp_rs = slv_resp(a);
    if (wr) begin
      exp_rd  = 32'h0;
      exp_lat = ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) + cfg_b_dly + 3;
      if (exp_rs == 2'd0) model_write(a, d, s);
    end else begin
      exp_rd  = (exp_rs == 2'd0) ? model_read(a) : (32'hBAD0_0000 | a);
      exp_lat = cfg_ar_dly + cfg_r_dly + 3;
    end
    issue(wr, a, d, s);
    wait_rsp(wr, rd, rs, lat, v1);
    check({tag, "_resp"}, 64'(rs), 64'(exp_rs));
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_valid_cycle1"}, 64'(v1), 64'd1);
    check({tag, "_addr"}, 64'(wr ? last_awaddr : last_araddr), 64'(a));
  endtask

  initial begin : main
    logic [31:0] rd, d;
    logic [1:0]  rs;
    logic [3:0]  s;
    int unsigned lat, bc, n, sel;
    logic        v1, wr;
    i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    check("reset_ctrl", {56'd0, o_cmd_ready, o_rsp_valid, o_busy, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, 64'd0);
    check("reset_addr", {o_awaddr, o_araddr}, 64'd0);
    check("reset_data", {o_wdata, o_rsp_rdata}, 64'd0);
    check("reset_strb_resp", {58'd0, o_wstrb, o_rsp_resp}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", {62'd0, o_cmd_ready, o_busy}, 64'd2);

    do_txn(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, "wr4");
    do_txn(1'b0, 32'h4, 32'h0, 4'h0, "rd4");

    cfg_aw_dly = 3; bc = b_count;
    do_txn(1'b1, 32'hC, 32'h0BAD_F00D, 4'hF, "w_before_aw");
    check("w_before_aw_bcount", 64'(b_count - bc), 64'd1);
    cfg_aw_dly = 0;
    do_txn(1'b0, 32'hC, 32'h0, 4'h0, "rd_c");
    do_txn(1'b1, 32'hC, 32'h1122_3344, 4'h5, "wr_c_partial");
    do_txn(1'b0, 32'hC, 32'h0, 4'h0, "rd_c_partial");

    i_rsp_ready = 1'b0;
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    wait_rsp(1'b0, rd, rs, lat, v1);
    i_cmd_write = 1'b1; i_cmd_addr = 32'h10; i_cmd_wdata = 32'hFFFF_FFFF; i_cmd_wstrb = 4'hF;
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", {62'd0, o_rsp_valid, o_cmd_ready}, 64'd2);
      check("hold_data", {30'd0, o_rsp_resp, o_rsp_rdata}, {30'd0, 2'd0, model_read(32'h4)});
    end
    i_cmd_valid = 1'b0; i_rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release", {62'd0, o_rsp_valid, o_cmd_ready}, 64'd1);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, "rd_unaccepted");

    do_txn(1'b1, 32'hE00, 32'h5555_AAAA, 4'hF, "wr_slverr");
    do_txn(1'b0, 32'hD04, 32'h0, 4'h0, "rd_decerr");

    cfg_r_dly = 50;
    issue(1'b0, 32'h4, 32'h0, 4'h0);
    n = 0;
    while (!o_rready && n < 20) begin @(negedge clk); n++; end
    check("rd_data_reached", 64'(o_rready), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {56'd0, o_cmd_ready, o_rsp_valid, o_busy, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready}, 64'd0);
    check("abort_payload", {o_awaddr, o_rsp_rdata}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; cfg_r_dly = 0;
    @(negedge clk);
    do_txn(1'b1, 32'h8, 32'hCAFE_0008, 4'hF, "wr8_after_reset");
    do_txn(1'b0, 32'h8, 32'h0, 4'h0, "rd8_after_reset");

`ifdef AXI_CMD_TIMEOUT_EN
    cfg_b_dly = 40; bc = b_count;
    issue(1'b1, 32'h14, 32'h1234_5678, 4'hF);
    wait_rsp(1'b1, rd, rs, lat, v1);
    check("tmo_resp", 64'(rs), 64'd3);
    check("tmo_rdata", 64'(rd), 64'd0);
    check("tmo_latency", 64'(lat), 64'(TMO + 2));
    check("drain_block", {62'd0, o_cmd_ready, o_bready}, 64'd1);
    n = 0;
    while (b_count == bc && n < 100) begin @(negedge clk); n++; end
    check("drain_bcount", 64'(b_count - bc), 64'd1);
    check("drain_done_ready", 64'(o_cmd_ready), 64'd1);
    cfg_b_dly = 0;
    model_write(32'h14, 32'h1234_5678, 4'hF);
    do_txn(1'b0, 32'h14, 32'h0, 4'h0, "rd_after_drain");
`endif

    for (int t = 0; t < 40; t++) begin
      cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3);
      cfg_b_dly  = $urandom_range(0, 3); cfg_ar_dly = $urandom_range(0, 3);
      cfg_r_dly  = $urandom_range(0, 3);
      sel = $urandom_range(0, 19);
      wr  = 1'($urandom_range(0, 1));
      d   = $urandom;
      s   = 4'($urandom_range(1, 15));
      do_txn(wr, (sel < 16) ? 32'(sel * 4) : ((sel < 18) ? 32'hE08 : 32'hD0C), d, s, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
